// File: rtl/cfa_frame_sched.sv
// ---------------------------------------------------------------------------
// cfa_frame_sched
//
// Frame sequencer feeding the Bayer demosaic (CFA) stage from a raw pixel
// buffer with one-cycle synchronous read latency. It produces the
// vsync/hsync/den framing, issues pixel read requests one cycle ahead of
// every den cycle (with x/y coordinates), and forwards the returned raw
// pixel aligned to den. Single-shot or continuous frames.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           frame start pulse, accepted only while idle
//   cont            continuous mode, looked at only when the inter-frame
//                   gap ends
//   clr_err         clears start_dropped
//   pix_req/x/y     buffer read strobe and coordinates (0 when no request)
//   pix_data        raw pixel, returned the cycle after pix_req
//   out_vsync/hsync/den/raw   framing and data towards the CFA stage
//   busy            sequencer not idle
//   done            one-cycle pulse in the first gap cycle after a frame
//   frame_cnt       completed frames, wrapping
//   start_dropped   sticky flag: start arrived while not idle
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module cfa_frame_sched #(
    parameter int H_ACTIVE = 512,
    parameter int V_ACTIVE = 512,
    parameter int H_BLANK  = 16,
    parameter int V_PRE    = 4,
    parameter int V_POST   = 4,
    parameter int V_GAP    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cont,
    input  logic       clr_err,
    output logic       pix_req,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    input  logic [7:0] pix_data,
    output logic       out_vsync,
    output logic       out_hsync,
    output logic       out_den,
    output logic [7:0] out_raw,
    output logic       busy,
    output logic       done,
    output logic [7:0] frame_cnt,
    output logic       start_dropped
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VPRE,
        S_ACTIVE,
        S_HBLANK,
        S_VPOST,
        S_GAP
    } state_t;

    // Last count value of each timed state.
    localparam logic [9:0] HA_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0] VA_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HB_LAST   = 10'(H_BLANK - 1);
    localparam logic [9:0] VPRE_LAST = 10'(V_PRE - 1);
    localparam logic [9:0] VPST_LAST = 10'(V_POST - 1);
    localparam logic [9:0] GAP_LAST  = 10'(V_GAP - 1);

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [9:0] y_q, y_d;

    logic       pix_req_q, pix_req_d;
    logic [9:0] pix_x_q, pix_x_d;
    logic [9:0] pix_y_q, pix_y_d;
    logic       vsync_q, hsync_q, den_q, busy_q, done_q, dropped_q;
    logic [7:0] frame_cnt_q;
    logic       frame_end;

    // Next state of the sequencer (the state of the coming cycle).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 10'd1;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_VPRE;
                    y_d     = '0;
                end
            end
            S_VPRE: begin
                if (cnt_q == VPRE_LAST) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end
            end
            S_ACTIVE: begin
                if (cnt_q == HA_LAST) begin
                    cnt_d   = '0;
                    state_d = (y_q == VA_LAST) ? S_VPOST : S_HBLANK;
                end
            end
            S_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                    y_d     = y_q + 10'd1;
                end
            end
            S_VPOST: begin
                if (cnt_q == VPST_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (cont) begin
                        state_d = S_VPRE;
                        y_d     = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The read request has to lead den by one cycle while still being a
    // registered output, so it is derived from the state two cycles ahead:
    // the coming cycle (state_d/cnt_d) and whether the cycle after it is an
    // active pixel.
    always_comb begin
        pix_req_d = ((state_d == S_ACTIVE) && (cnt_d != HA_LAST)) ||
                    ((state_d == S_VPRE)   && (cnt_d == VPRE_LAST)) ||
                    ((state_d == S_HBLANK) && (cnt_d == HB_LAST));
        pix_x_d   = '0;
        pix_y_d   = '0;
        if (pix_req_d) begin
            pix_x_d = (state_d == S_ACTIVE) ? cnt_d + 10'd1 : 10'd0;
            pix_y_d = (state_d == S_HBLANK) ? y_d + 10'd1 : y_d;
        end
    end

    assign frame_end = (state_d == S_GAP) && (state_q != S_GAP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            y_q         <= '0;
            pix_req_q   <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            vsync_q     <= 1'b0;
            hsync_q     <= 1'b0;
            den_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            pix_req_q   <= pix_req_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            vsync_q     <= (state_d == S_VPRE) || (state_d == S_ACTIVE) ||
                           (state_d == S_HBLANK) || (state_d == S_VPOST);
            hsync_q     <= (state_d == S_ACTIVE);
            den_q       <= (state_d == S_ACTIVE);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= frame_end;
            if (frame_end) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            // A new drop event wins over a simultaneous clear.
            if (start && (state_q != S_IDLE)) begin
                dropped_q <= 1'b1;
            end else if (clr_err) begin
                dropped_q <= 1'b0;
            end
        end
    end

    assign pix_req       = pix_req_q;
    assign pix_x         = pix_x_q;
    assign pix_y         = pix_y_q;
    assign out_vsync     = vsync_q;
    assign out_hsync     = hsync_q;
    assign out_den       = den_q;
    assign out_raw       = den_q ? pix_data : 8'h00;
    assign busy          = busy_q;
    assign done          = done_q;
    assign frame_cnt     = frame_cnt_q;
    assign start_dropped = dropped_q;

endmodule

// File: tb/tb_cfa_frame_sched.sv
`timescale 1ns/1ps

module tb_cfa_frame_sched;

    localparam int HA  = 4;
    localparam int VA  = 3;
    localparam int HB  = 2;
    localparam int VP  = 3;
    localparam int VPO = 2;
    localparam int VG  = 2;
    localparam int P   = HA + HB;
    localparam int L   = VP + (VA - 1) * P + HA;  // last active cycle
    localparam int D   = L + VPO + 1;             // done cycle
    localparam int F   = L + VPO + VG;            // frame period in continuous mode

    typedef struct packed {
        logic       busy;
        logic       vs;
        logic       hs;
        logic       den;
        logic       req;
        logic       done;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] fc;
        logic [7:0] raw;
        logic       sd;
    } obs_t;

    logic       clk;
    logic       reset, start, cont, clr_err;
    logic       pix_req;
    logic [9:0] pix_x, pix_y;
    logic [7:0] pix_data;
    logic       out_vsync, out_hsync, out_den;
    logic [7:0] out_raw;
    logic       busy, done;
    logic [7:0] frame_cnt;
    logic       start_dropped;
    obs_t       obs;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] fc_m;
    logic       sd_m;

    cfa_frame_sched #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .V_PRE(VP), .V_POST(VPO), .V_GAP(VG)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cont(cont), .clr_err(clr_err),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .out_vsync(out_vsync), .out_hsync(out_hsync), .out_den(out_den),
        .out_raw(out_raw), .busy(busy), .done(done), .frame_cnt(frame_cnt),
        .start_dropped(start_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel buffer: a requested pixel holds 16*y+x; otherwise junk.
    always @(posedge clk) begin
        if (pix_req) pix_data <= {pix_y[3:0], pix_x[3:0]};
        else         pix_data <= 8'($urandom);
    end

    assign obs = {busy, out_vsync, out_hsync, out_den, pix_req, done,
                  pix_x, pix_y, frame_cnt, out_raw, start_dropped};

    // Is relative cycle r an active pixel cycle; which line/column.
    function automatic bit act(input int r, output int ln, output int cl);
        ln = 0;
        cl = 0;
        if (r < VP + 1 || r > L) return 1'b0;
        ln = (r - VP - 1) / P;
        cl = (r - VP - 1) % P;
        return (cl < HA);
    endfunction

    // Expected outputs t cycles after the start pulse of a train of n frames.
    function automatic obs_t model(input int t, input int n,
                                   input logic [7:0] fc0, input logic sd);
        obs_t e;
        int   k, r, nd, ln, cl;
        e    = '0;
        e.sd = sd;
        nd   = (t >= D) ? (t - D) / F + 1 : 0;
        if (nd > n) nd = n;
        e.fc = fc0 + 8'(nd);
        if (t >= 1 && t <= n * F) begin
            e.busy = 1'b1;
            k = t / F;
            if (k > n - 1) k = n - 1;
            r = t - k * F;
            e.vs   = (r >= 1 && r <= L + VPO);
            e.done = (r == D);
            if (act(r, ln, cl)) begin
                e.hs  = 1'b1;
                e.den = 1'b1;
                e.raw = 8'(ln * 16 + cl);
            end
            if (act(r + 1, ln, cl)) begin
                e.req = 1'b1;
                e.x   = 10'(cl);
                e.y   = 10'(ln);
            end
        end
        return e;
    endfunction

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b1; cont = 1'b1; clr_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== obs_t'('0)) begin
                n_fail++;
                $display("FAIL reset i=%0d got=%h exp=0", i, obs);
            end
            if (i == 2) begin
                reset = 1'b0; start = 1'b0; cont = 1'b0;
            end
        end
        fc_m = 8'd0;
        sd_m = 1'b0;
    endtask

    task automatic test_spec_timing();
        logic [5:0] got, exp;
        bit evs, eden, ereq;
        for (int t = 0; t <= 26; t++) begin
            @(posedge clk); #1;
            evs  = (t >= 1 && t <= 21);
            eden = (t >= 4 && t <= 7) || (t >= 10 && t <= 13) || (t >= 16 && t <= 19);
            ereq = (t >= 3 && t <= 6) || (t >= 9 && t <= 12) || (t >= 15 && t <= 18);
            got  = {out_vsync, out_hsync, out_den, pix_req, done, busy};
            exp  = {evs, eden, eden, ereq, (t == 22), (t >= 1 && t <= 23)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL spec_timing t=%0d vs/hs/den/req/done/busy got=%b exp=%b", t, got, exp);
            end
            if (t == 22) begin
                n_checks++;
                if (frame_cnt !== fc_m + 8'd1) begin
                    n_fail++;
                    $display("FAIL spec_frame_cnt got=%0d exp=%0d", frame_cnt, fc_m + 8'd1);
                end
            end
            start = (t == 0); cont = 1'b0; clr_err = 1'b0;
        end
        fc_m = fc_m + 8'd1;
    endtask

    task automatic test_data_path();
        logic [7:0] q[$];
        for (int t = 0; t <= 26; t++) begin
            @(posedge clk); #1;
            if (out_den) q.push_back(out_raw);
            else begin
                n_checks++;
                if (out_raw !== 8'h00) begin
                    n_fail++;
                    $display("FAIL raw_idle t=%0d got=%h exp=00", t, out_raw);
                end
            end
            start = (t == 0); cont = 1'b0; clr_err = 1'b0;
        end
        n_checks++;
        if (q.size() != HA * VA) begin
            n_fail++;
            $display("FAIL raw_count got=%0d exp=%0d", q.size(), HA * VA);
        end else begin
            for (int i = 0; i < HA * VA; i++) begin
                n_checks++;
                if (q[i] !== 8'((i / HA) * 16 + (i % HA))) begin
                    n_fail++;
                    $display("FAIL raw_seq i=%0d got=%h exp=%h", i, q[i], 8'((i / HA) * 16 + (i % HA)));
                end
            end
        end
        fc_m = fc_m + 8'd1;
    endtask

    // Train of n frames with random dropped starts, clears and cont noise.
    task automatic test_frames(input int n, input string tag);
        obs_t e;
        bit   last;
        for (int t = 0; t <= n * F + 2; t++) begin
            @(posedge clk); #1;
            e = model(t, n, fc_m, sd_m);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s t=%0d got=%h exp=%h", tag, t, obs, e);
            end
            last = (t == n * F + 2);
            if (t == 0) start = 1'b1;
            else        start = !last && e.busy && ($urandom_range(0, 15) == 0);
            clr_err = !last && ($urandom_range(0, 7) == 0);
            if (t >= F && t % F == 0 && t <= n * F) cont = (t < n * F);
            else                                    cont = !last && ($urandom_range(0, 1) == 1);
            if (start && e.busy) sd_m = 1'b1;
            else if (clr_err)    sd_m = 1'b0;
        end
        fc_m = fc_m + 8'(n);
    endtask

    task automatic test_continuous();
        logic [7:0] fc0;
        fc0 = fc_m;
        for (int t = 0; t <= 50; t++) begin
            @(posedge clk); #1;
            if (t == 22 || t == 45) begin
                n_checks++;
                if (done !== 1'b1 || frame_cnt !== fc0 + 8'((t == 22) ? 1 : 2)) begin
                    n_fail++;
                    $display("FAIL cont_done t=%0d done=%b fc=%0d exp done=1 fc=%0d",
                             t, done, frame_cnt, fc0 + 8'((t == 22) ? 1 : 2));
                end
            end
            if (t == 23 || t == 24) begin
                n_checks++;
                if (out_vsync !== (t == 24) || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL cont_restart t=%0d vs=%b busy=%b exp vs=%b busy=1",
                             t, out_vsync, busy, (t == 24));
                end
            end
            if (t == 47) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cont_stop busy=%b exp=0", busy);
                end
            end
            start = (t == 0); cont = (t < 30); clr_err = 1'b0;
        end
        fc_m = fc_m + 8'd2;
    endtask

    task automatic test_start_dropped();
        obs_t e;
        for (int t = 0; t <= 32; t++) begin
            @(posedge clk); #1;
            e = model(t, 1, fc_m, sd_m);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL dropped t=%0d got=%h exp=%h", t, obs, e);
            end
            if (t == 11 || t == 13 || t == 31) begin
                n_checks++;
                if (start_dropped !== (t != 31)) begin
                    n_fail++;
                    $display("FAIL dropped_flag t=%0d got=%b exp=%b", t, start_dropped, (t != 31));
                end
            end
            start   = (t == 0 || t == 10 || t == 12);
            clr_err = (t == 0 || t == 12 || t == 30);
            cont    = 1'b0;
            if (start && e.busy) sd_m = 1'b1;
            else if (clr_err)    sd_m = 1'b0;
        end
        fc_m = fc_m + 8'd1;
    endtask

    task automatic test_reset_midframe();
        obs_t e;
        for (int t = 0; t <= 15 + F + 2; t++) begin
            @(posedge clk); #1;
            if (t <= 12)      e = model(t, 1, fc_m, sd_m);
            else if (t <= 14) e = '0;
            else              e = model(t - 15, 1, 8'd0, 1'b0);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid t=%0d got=%h exp=%h", t, obs, e);
            end
            if (t == 16) begin
                n_checks++;
                if (out_vsync !== 1'b1 || pix_y !== 10'd0) begin
                    n_fail++;
                    $display("FAIL reset_restart vs=%b y=%0d exp vs=1 y=0", out_vsync, pix_y);
                end
            end
            start = (t == 0 || t == 15); reset = (t == 12); clr_err = 1'b0; cont = 1'b0;
        end
        fc_m = 8'd1;
        sd_m = 1'b0;
    endtask

    task automatic test_wrap();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        fc_m = 8'd0;
        sd_m = 1'b0;
        test_frames(256, "wrap");
        @(posedge clk); #1;
        n_checks++;
        if (frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_frame_cnt got=%0d exp=0", frame_cnt);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; cont = 1'b0; clr_err = 1'b0;
        fc_m = 8'd0; sd_m = 1'b0;
        test_reset();
        test_spec_timing();
        test_data_path();
        test_frames(1, "single");
        test_frames(2, "continuous");
        test_continuous();
        test_start_dropped();
        test_reset_midframe();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cfa_frame_sched.md
# cfa_frame_sched

Frame sequencer that drives the Bayer demosaic (CFA) stage from a synchronous-read raw pixel buffer. It generates the vsync/hsync/den framing the CFA stage expects, issues one-ahead pixel read requests with x/y coordinates, and forwards returned raw data aligned to den. It supports single-shot or continuous frames and reports completion and protocol errors.

## Interface
Parameters:
- H_ACTIVE, 512, active pixels per line (1..1024)
- V_ACTIVE, 512, active lines per frame (1..1024)
- H_BLANK, 16, hsync-low cycles between lines (>=1; CFA needs an hsync low to reset its column index)
- V_PRE, 4, vsync-high cycles before the first line (>=1)
- V_POST, 4, vsync-high cycles after the last line (>=1)
- V_GAP, 8, vsync-low cycles between frames in continuous mode (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  frame start pulse; accepted only in IDLE
- cont  in  1  continuous mode; sampled at the end of GAP
- clr_err  in  1  clears start_dropped
- pix_req  out  1  buffer read strobe; data is due next cycle
- pix_x  out  10  column of requested pixel, valid with pix_req
- pix_y  out  10  line of requested pixel, valid with pix_req
- pix_data  in  8  raw pixel returned one cycle after pix_req
- out_vsync  out  1  to CFA in_vsync
- out_hsync  out  1  to CFA in_hsync
- out_den  out  1  to CFA in_den
- out_raw  out  8  to CFA in_raw; pix_data when out_den=1, else 8'h00 (combinational)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at frame end
- frame_cnt  out  8  completed frames, wraps 255->0
- start_dropped  out  1  sticky: start seen outside IDLE

## Operation
- FSM states: IDLE, VPRE, ACTIVE, HBLANK, VPOST, GAP. One cycle counter (<=10 bits) plus line counter y.
- IDLE: all framing low. start=1 → VPRE, y=0.
- VPRE: vsync=1 for V_PRE cycles → ACTIVE.
- ACTIVE: vsync=hsync=den=1 for H_ACTIVE cycles. Then y==V_ACTIVE-1 → VPOST, else → HBLANK.
- HBLANK: vsync=1, hsync=den=0 for H_BLANK cycles; y increments on exit → ACTIVE.
- VPOST: vsync=1 for V_POST cycles → GAP.
- GAP: all framing low for V_GAP cycles. done=1 and frame_cnt+1 in the first GAP cycle. At exit: cont=1 → VPRE (y=0), else → IDLE.
- pix_req is asserted exactly in the cycle before every out_den=1 cycle, so H_ACTIVE×V_ACTIVE requests per frame. pix_x runs 0..H_ACTIVE-1 and pix_y = line. pix_x/pix_y are 0 when pix_req=0.
- The x counter is 10-bit and must not wrap within a line.
- start in any non-IDLE state is ignored and sets start_dropped. clr_err clears start_dropped; a simultaneous set takes priority over clear.
- start and cont are not sampled in GAP; only cont is sampled, at GAP exit.

## Timing
- All outputs are registered except out_raw. Framing and pix_req change on the clock edge after the cause.
- Cycle numbering: start is high in cycle 0 (IDLE), so vsync rises in cycle 1.
  - Line y is active in cycles V_PRE+1+y·(H_ACTIVE+H_BLANK) through that value +H_ACTIVE-1.
  - pix_req leads each active cycle by 1.
  - Last active cycle L = V_PRE+(V_ACTIVE-1)·(H_ACTIVE+H_BLANK)+H_ACTIVE.
  - vsync falls, done pulses and frame_cnt increments in cycle L+V_POST+1.
  - busy falls in cycle L+V_POST+V_GAP+1 (single-shot).
- Continuous mode: the next vsync rises in cycle L+V_POST+V_GAP+1, with no IDLE cycle in between.
- hsync rises once per line. CFA line counting therefore equals y+1.
- Reset (priority over all inputs) forces the following at the next edge, including mid-frame: state IDLE, counters 0, every registered output 0 (pix_req, pix_x, pix_y, vsync, hsync, den, busy, done, frame_cnt, start_dropped). No partial frame resumes afterwards.

## Test plan
- Single frame, H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, V_PRE=3, V_POST=2, V_GAP=2, start in cycle 0:
  - vsync high in cycles 1–21; den/hsync high in cycles 4–7, 10–13 and 16–19; pix_req in cycles 3–6, 9–12 and 15–18.
  - done in cycle 22, busy low from cycle 24, frame_cnt=1.
- Data path: buffer returns pix_data=16·y+x → out_raw sequence 00,01,02,03,10,…,23 on den cycles; 00 when den=0.
- Continuous: same params, cont=1 throughout → second vsync rises in cycle 24; frame_cnt=2 after the second done in cycle 45.
- start pulsed in cycle 10 mid-frame → start_dropped=1, frame timing unchanged; clr_err in cycle 30 → start_dropped=0.
- Reset asserted in cycle 12 (during line 1) → all outputs 0 from cycle 13; a new start in cycle 15 restarts at y=0 with vsync rising in cycle 16.
- frame_cnt wrap: run 256 continuous frames → frame_cnt reads 0 after the 256th done.
